// File: rtl/ptp_tx_pkg.sv
// ptp_tx_pkg
//   Definitions shared by the PTP transmit path: input FSM state encoding,
//   the PTP frame-type code, timestamp width and the byte positions that
//   carry the receive timestamp inside a frame.
package ptp_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2,
    DISC = 2'd3
  } tx_state_t;

  localparam logic [2:0] PTP_TYPE   = 3'd4;
  localparam int         TS_W       = 19;
  // Receive timestamp occupies bytes 3..5: [2:0] of byte 3, all of 4 and 5.
  localparam logic [2:0] TS_BYTE_HI = 3'd3;
  localparam logic [2:0] TS_BYTE_LO = 3'd5;

endpackage

// File: rtl/ptp_tx_delay_line.sv
// ptp_tx_delay_line
//   DEPTH-stage shift register of {valid, last, data[8:0]} that advances every
//   cycle. Stage 0 loads the input; stage k loads stage k-1. While ovr_en is
//   high the data bytes moving into the two last stages are replaced:
//   ovr_hi lands in stage DEPTH-1, ovr_lo in stage DEPTH-2. Bit 8 is never
//   touched.
// Ports:
//   clk_sys, reset             clock, synchronous active-high reset
//   in_valid/in_last/in_data   stage-0 load
//   ovr_en, ovr_hi, ovr_lo     byte overwrite of the two last stages
//   stage_valid/last/data      current contents of every stage
module ptp_tx_delay_line #(
  parameter int DEPTH = 3
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [8:0]            in_data,
  input  logic                  ovr_en,
  input  logic [7:0]            ovr_hi,
  input  logic [7:0]            ovr_lo,
  output logic [DEPTH-1:0]      stage_valid,
  output logic [DEPTH-1:0]      stage_last,
  output logic [DEPTH-1:0][8:0] stage_data
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      localparam bit OVR_STAGE = (gi > 0) && (gi >= DEPTH - 2);

      logic       src_valid;
      logic       src_last;
      logic [8:0] src_data;
      logic [7:0] ovr_byte;
      logic       valid_reg;
      logic       last_reg;
      logic [8:0] data_reg;

      if (gi == 0) begin : g_src_in
        assign src_valid = in_valid;
        assign src_last  = in_last;
        assign src_data  = in_data;
      end else begin : g_src_prev
        assign src_valid = stage_valid[gi-1];
        assign src_last  = stage_last[gi-1];
        assign src_data  = stage_data[gi-1];
      end

      if (gi == DEPTH - 1) begin : g_ovr_hi
        assign ovr_byte = ovr_hi;
      end else begin : g_ovr_lo
        assign ovr_byte = ovr_lo;
      end

      always_ff @(posedge clk_sys) begin
        if (reset) begin
          valid_reg <= 1'b0;
          last_reg  <= 1'b0;
          data_reg  <= 9'h000;
        end else begin
          valid_reg     <= src_valid;
          last_reg      <= src_last;
          data_reg[8]   <= src_data[8];
          data_reg[7:0] <= (ovr_en && OVR_STAGE) ? ovr_byte : src_data[7:0];
        end
      end

      assign stage_valid[gi] = valid_reg;
      assign stage_last[gi]  = last_reg;
      assign stage_data[gi]  = data_reg;
    end
  endgenerate

endmodule

// File: rtl/ptp_frame_transmit.sv
// ptp_frame_transmit
//   Re-emits the 9-bit framed byte stream with a fixed 4-cycle latency. In PTP
//   frames the 19-bit receive timestamp in bytes 3..5 is replaced by the
//   residence time (time latched at the head minus receive timestamp, mod
//   2^19). Stray bytes, short frames and gaps raise an error pulse; bytes of a
//   broken frame after the gap are discarded up to its tail.
// Ports:
//   clk_sys, reset              clock, synchronous active-high reset
//   iv_data, i_data_wr          input stream ([8] marks head and tail)
//   iv_tx_ts                    free-running local time
//   ov_data, o_data_wr          output stream
//   o_pkt_send_pulse            with every output byte that closes a frame
//   o_frame_err_pulse           one cycle after a malformed input byte/gap
//   ov_residence_time           last computed residence time
//   ov_tx_pkt_cnt               frames sent (wrapping)
//   ov_port_id                  constant outport
//   ov_transmit_state           input FSM state
module ptp_frame_transmit #(
  parameter logic [3:0] outport  = 4'b0000,
  parameter logic [2:0] PTP_TYPE = ptp_tx_pkg::PTP_TYPE
) (
  input  logic                        clk_sys,
  input  logic                        reset,
  input  logic [8:0]                  iv_data,
  input  logic                        i_data_wr,
  input  logic [ptp_tx_pkg::TS_W-1:0] iv_tx_ts,
  output logic [8:0]                  ov_data,
  output logic                        o_data_wr,
  output logic                        o_pkt_send_pulse,
  output logic                        o_frame_err_pulse,
  output logic [ptp_tx_pkg::TS_W-1:0] ov_residence_time,
  output logic [15:0]                 ov_tx_pkt_cnt,
  output logic [3:0]                  ov_port_id,
  output logic [1:0]                  ov_transmit_state
);
  import ptp_tx_pkg::*;

  // The three timestamp bytes must sit in the delay line at the same time.
  localparam int TS_SPAN = int'(TS_BYTE_LO) - int'(TS_BYTE_HI) + 1;

  tx_state_t         state_reg, state_next;
  logic [2:0]        byte_cnt_reg, byte_cnt_next;
  logic [2:0]        type_reg, type_next;
  logic [TS_W-1:0]   ts_l_reg, ts_l_next;
  logic              arm_reg, arm_next;
  logic              accept;
  logic              in_last;
  logic              err_next;

  logic [TS_SPAN-1:0]      s_valid;
  logic [TS_SPAN-1:0]      s_last;
  logic [TS_SPAN-1:0][8:0] s_data;
  logic [TS_W-1:0]         rec_ts;
  logic [TS_W-1:0]         diff;

  always_comb begin
    state_next    = state_reg;
    byte_cnt_next = byte_cnt_reg;
    type_next     = type_reg;
    ts_l_next     = ts_l_reg;
    arm_next      = 1'b0;
    accept        = 1'b0;
    err_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_data_wr) begin
          if (iv_data[8]) begin
            accept        = 1'b1;
            type_next     = iv_data[7:5];
            ts_l_next     = iv_tx_ts;
            byte_cnt_next = 3'd1;
            state_next    = HDR;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      HDR: begin
        if (i_data_wr) begin
          accept = 1'b1;
          if (iv_data[8]) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end else begin
            byte_cnt_next = byte_cnt_reg + 3'd1;
            if (byte_cnt_reg == TS_BYTE_LO) begin
              state_next = BODY;
              // One cycle later bytes 3..5 fill the delay line.
              arm_next   = (type_reg == PTP_TYPE);
            end
          end
        end else begin
          err_next   = 1'b1;
          state_next = DISC;
        end
      end
      BODY: begin
        if (i_data_wr) begin
          accept = 1'b1;
          if (iv_data[8]) state_next = IDLE;
        end else begin
          err_next   = 1'b1;
          state_next = DISC;
        end
      end
      default: begin
        // DISC: a flagged byte is taken as the tail of the broken frame.
        if (i_data_wr && iv_data[8]) state_next = IDLE;
      end
    endcase
  end

  // A flagged byte is a tail everywhere except when it opens a frame.
  assign in_last = iv_data[8] && (state_reg != IDLE);

  assign rec_ts = {s_data[TS_SPAN-1][2:0], s_data[TS_SPAN-2][7:0], s_data[TS_SPAN-3][7:0]};
  assign diff   = ts_l_reg - rec_ts;

  ptp_tx_delay_line #(
    .DEPTH (TS_SPAN)
  ) u_delay (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .in_valid    (i_data_wr & accept),
    .in_last     (in_last),
    .in_data     (iv_data),
    .ovr_en      (arm_reg),
    .ovr_hi      (diff[15:8]),
    .ovr_lo      (diff[7:0]),
    .stage_valid (s_valid),
    .stage_last  (s_last),
    .stage_data  (s_data)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg         <= IDLE;
      byte_cnt_reg      <= 3'd0;
      type_reg          <= 3'd0;
      ts_l_reg          <= '0;
      arm_reg           <= 1'b0;
      ov_data           <= 9'h000;
      o_data_wr         <= 1'b0;
      o_pkt_send_pulse  <= 1'b0;
      o_frame_err_pulse <= 1'b0;
      ov_residence_time <= '0;
      ov_tx_pkt_cnt     <= 16'h0000;
    end else begin
      state_reg         <= state_next;
      byte_cnt_reg      <= byte_cnt_next;
      type_reg          <= type_next;
      ts_l_reg          <= ts_l_next;
      arm_reg           <= arm_next;
      o_frame_err_pulse <= err_next;
      o_data_wr         <= s_valid[TS_SPAN-1];
      o_pkt_send_pulse  <= s_valid[TS_SPAN-1] & s_last[TS_SPAN-1];
      if (s_valid[TS_SPAN-1] && s_last[TS_SPAN-1]) ov_tx_pkt_cnt <= ov_tx_pkt_cnt + 16'd1;
      if (arm_reg) begin
        ov_data           <= {s_data[TS_SPAN-1][8:3], diff[TS_W-1:16]};
        ov_residence_time <= diff;
      end else begin
        ov_data <= s_data[TS_SPAN-1];
      end
    end
  end

  assign ov_port_id        = outport;
  assign ov_transmit_state = state_reg;

endmodule
